// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types, widths and frame layout for the MCP4911 SPI transmitter
//
// Purpose: state encoding, frame/data widths, config bit positions and the
// frame-word builder used by dac_spi_tx.
// Ports: none (package).

package dac_pkg;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 10;

  // Bit positions inside the 16-bit DAC write word (MSB is sent first).
  localparam int POS_AB       = 15;  // channel select, always 0 on a single-channel part
  localparam int POS_BUF      = 14;
  localparam int POS_GA_N     = 13;
  localparam int POS_SHDN_N   = 12;
  localparam int POS_DATA_LSB = 2;   // data[9:0] sits in [11:2], [1:0] are don't-care zeros

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_CS_GAP,
    ST_LDAC
  } state_t;

  function automatic logic [FRAME_W-1:0] make_frame(
    input logic [DATA_W-1:0] data,
    input logic              buf_bit,
    input logic              ga_n_bit
  );
    logic [FRAME_W-1:0] f;
    f                             = '0;
    f[POS_AB]                     = 1'b0;
    f[POS_BUF]                    = buf_bit;
    f[POS_GA_N]                   = ga_n_bit;
    f[POS_SHDN_N]                 = 1'b1;
    f[POS_DATA_LSB +: DATA_W]     = data;
    return f;
  endfunction

endpackage

// File: rtl/dac_spi_tx_phase_tick.sv
// rtl/dac_spi_tx_phase_tick.sv - divide-by-CLK_DIV phase tick generator
//
// Purpose: counts sysclk cycles and raises tick on the last cycle of every
// CLK_DIV-long dwell. A state change restarts the count so each new state
// gets a full dwell.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   clear  - restart the dwell count (state is changing this cycle)
//   tick   - high on the final cycle of the current dwell

module phase_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - 10-bit sample to MCP4911 16-bit SPI write-frame serialiser
//
// Purpose: takes one DAC code per load strobe, sends it as a 16-bit SPI word
// (MSB first, DAC samples on SCK rise), then pulses LDAC. A one-entry pending
// buffer holds a sample that arrives while a frame is in flight.
// Ports:
//   sysclk      - system clock
//   rst_n       - asynchronous active-low reset
//   data_in     - 10-bit offset-binary DAC code, taken when load=1
//   load        - one-cycle strobe, new sample available
//   busy        - frame in flight or sample pending
//   dropped     - one-cycle pulse when a pending sample is overwritten
//   dac_cs_n    - SPI chip select, active low
//   dac_sck     - SPI clock, idle low
//   dac_sdi     - SPI data out
//   dac_ldac_n  - DAC latch strobe, active low

module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic        BUF_BIT  = 1'b0,
  parameter logic        GA_N_BIT = 1'b1
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              busy,
  output logic              dropped,
  output logic              dac_cs_n,
  output logic              dac_sck,
  output logic              dac_sdi,
  output logic              dac_ldac_n
);

  state_t              state, state_nx;
  logic [FRAME_W-1:0]  sreg, sreg_nx;
  logic [3:0]          bit_cnt, bit_cnt_nx;
  logic                sck_hi, sck_hi_nx;
  logic                pend_vld, pend_vld_nx;
  logic [DATA_W-1:0]   pend_data, pend_data_nx;
  logic                drop_nx;
  logic                start;
  logic [DATA_W-1:0]   start_data;
  logic                cs_low_nx;
  logic                tick;
  logic                state_chg;

  assign state_chg = (state_nx != state);

  phase_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_tick (
    .clk   (sysclk),
    .rst_n (rst_n),
    .clear (state_chg),
    .tick  (tick)
  );

  always_comb begin
    state_nx     = state;
    sreg_nx      = sreg;
    bit_cnt_nx   = bit_cnt;
    sck_hi_nx    = sck_hi;
    pend_vld_nx  = pend_vld;
    pend_data_nx = pend_data;
    drop_nx      = 1'b0;
    start        = 1'b0;
    start_data   = pend_data;

    case (state)
      ST_IDLE: begin
        if (load) begin
          start      = 1'b1;
          start_data = data_in;
          drop_nx    = pend_vld;
        end else if (pend_vld) begin
          start = 1'b1;
        end
      end
      ST_CS_SETUP: begin
        if (tick) state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Each bit is a low dwell then a high dwell; the shift happens as SCK
        // falls so SDI is stable a full dwell either side of the rising edge.
        if (tick) begin
          if (!sck_hi) begin
            sck_hi_nx = 1'b1;
          end else begin
            sck_hi_nx  = 1'b0;
            sreg_nx    = {sreg[FRAME_W-2:0], 1'b0};
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) state_nx = ST_CS_HOLD;
          end
        end
      end
      ST_CS_HOLD: begin
        if (tick) state_nx = ST_CS_GAP;
      end
      ST_CS_GAP: begin
        if (tick) state_nx = ST_LDAC;
      end
      ST_LDAC: begin
        // A fresh load on the exit cycle beats the older pending sample.
        if (tick) begin
          if (load) begin
            start      = 1'b1;
            start_data = data_in;
            drop_nx    = pend_vld;
          end else if (pend_vld) begin
            start = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // A load not consumed directly by a frame start parks in the pending slot.
    if (load && !start && (state != ST_IDLE)) begin
      pend_vld_nx  = 1'b1;
      pend_data_nx = data_in;
      drop_nx      = pend_vld;
    end

    if (start) begin
      state_nx    = ST_CS_SETUP;
      sreg_nx     = make_frame(start_data, BUF_BIT, GA_N_BIT);
      bit_cnt_nx  = 4'd0;
      sck_hi_nx   = 1'b0;
      pend_vld_nx = 1'b0;
    end

    cs_low_nx = (state_nx == ST_CS_SETUP) || (state_nx == ST_SHIFT) ||
                (state_nx == ST_CS_HOLD);
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe, with no decode glitches on the SPI pins.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      bit_cnt    <= 4'd0;
      sck_hi     <= 1'b0;
      pend_vld   <= 1'b0;
      pend_data  <= '0;
      busy       <= 1'b0;
      dropped    <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_sck    <= 1'b0;
      dac_sdi    <= 1'b0;
      dac_ldac_n <= 1'b1;
    end else begin
      state      <= state_nx;
      sreg       <= sreg_nx;
      bit_cnt    <= bit_cnt_nx;
      sck_hi     <= sck_hi_nx;
      pend_vld   <= pend_vld_nx;
      pend_data  <= pend_data_nx;
      busy       <= (state_nx != ST_IDLE) || pend_vld_nx;
      dropped    <= drop_nx;
      dac_cs_n   <= !cs_low_nx;
      dac_sck    <= (state_nx == ST_SHIFT) && sck_hi_nx;
      dac_sdi    <= cs_low_nx && sreg_nx[FRAME_W-1];
      dac_ldac_n <= (state_nx != ST_LDAC);
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - self-checking bench for dac_spi_tx

module tb_dac_spi_tx;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic [9:0] data_in;
  logic       load;
  logic       busy, dropped, dac_cs_n, dac_sck, dac_sdi, dac_ldac_n;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sysclk = ~sysclk;

  dac_spi_tx #(
    .CLK_DIV  (2),
    .BUF_BIT  (1'b0),
    .GA_N_BIT (1'b1)
  ) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .load       (load),
    .busy       (busy),
    .dropped    (dropped),
    .dac_cs_n   (dac_cs_n),
    .dac_sck    (dac_sck),
    .dac_sdi    (dac_sdi),
    .dac_ldac_n (dac_ldac_n)
  );

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int rise_q[$], cs_q[$], ldac_q[$], busy_q[$];
  int n_drop = 0;

  logic p_cs = 1'b1, p_sck = 1'b0, p_ldac = 1'b1, p_busy = 1'b0;
  int cs_len = 0, ldac_len = 0, busy_len = 0, rises = 0;
  logic [15:0] shreg = '0;

  always @(negedge sysclk) begin
    if (p_cs && !dac_cs_n) begin
      cs_len = 1; rises = 0; shreg = '0;
    end else if (!dac_cs_n) begin
      cs_len++;
    end
    if (!p_sck && dac_sck) begin
      shreg = {shreg[14:0], dac_sdi};
      rises++;
    end
    if (!p_cs && dac_cs_n) begin
      got_q.push_back(shreg); rise_q.push_back(rises); cs_q.push_back(cs_len);
    end
    if (!dac_ldac_n) ldac_len = p_ldac ? 1 : ldac_len + 1;
    if (!p_ldac && dac_ldac_n) ldac_q.push_back(ldac_len);
    if (busy) busy_len = p_busy ? busy_len + 1 : 1;
    if (p_busy && !busy) busy_q.push_back(busy_len);
    if (dropped) n_drop++;
    p_cs = dac_cs_n; p_sck = dac_sck; p_ldac = dac_ldac_n; p_busy = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [9:0] d);
    return {4'b0011, d, 2'b00};
  endfunction

  task automatic send(input logic [9:0] d);
    @(negedge sysclk);
    data_in = d;
    load    = 1'b1;
    @(negedge sysclk);
    load    = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge sysclk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    chk({tag, "_idle_timeout"}, busy, 1'b0);
    repeat (2) @(negedge sysclk);
  endtask

  task automatic check_frame(input string tag);
    logic [31:0] g, e;
    e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
    g = (got_q.size() > 0) ? 32'(got_q.pop_front()) : 'x;
    chk({tag, "_frame"}, g, e);
    g = (rise_q.size() > 0) ? 32'(rise_q.pop_front()) : 'x;
    chk({tag, "_sck_rises"}, g, 16);
    g = (cs_q.size() > 0) ? 32'(cs_q.pop_front()) : 'x;
    chk({tag, "_cs_low"}, g, 68);
    g = (ldac_q.size() > 0) ? 32'(ldac_q.pop_front()) : 'x;
    chk({tag, "_ldac_low"}, g, 2);
  endtask

  task automatic check_busy(input string tag, input int exp_len);
    logic [31:0] g;
    g = (busy_q.size() > 0) ? 32'(busy_q.pop_front()) : 'x;
    chk({tag, "_busy_len"}, g, exp_len);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, dac_cs_n, 1'b1);
    chk({tag, "_sck"}, dac_sck, 1'b0);
    chk({tag, "_sdi"}, dac_sdi, 1'b0);
    chk({tag, "_ldac_n"}, dac_ldac_n, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_dropped"}, dropped, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    logic [9:0] d;

    rst_n   = 1'b0;
    load    = 1'b0;
    data_in = '0;

    // Reset held 5 cycles, outputs quiet before and after release.
    repeat (5) @(negedge sysclk);
    check_reset_outputs("rst_held");
    rst_n = 1'b1;
    repeat (6) @(negedge sysclk);
    check_reset_outputs("rst_released");

    // Single sample with latency checks.
    exp_q.push_back(16'h3A94);
    send(10'h2A5);
    chk("lat_cs_fall", dac_cs_n, 1'b0);
    chk("lat_busy_rise", busy, 1'b1);
    n = 0;
    while (dac_sck !== 1'b1 && n < 20) begin
      @(negedge sysclk);
      n++;
    end
    chk("lat_first_sck", n, 4);
    wait_idle("single", 200);
    check_frame("single");
    check_busy("single", 72);

    // Extremes.
    exp_q.push_back(16'h3000);
    send(10'h000);
    wait_idle("zero", 200);
    check_frame("zero");
    check_busy("zero", 72);

    exp_q.push_back(16'h3FFC);
    send(10'h3FF);
    wait_idle("full", 200);
    check_frame("full");
    check_busy("full", 72);

    // Back-to-back every 72 cycles: no drops, busy stays high throughout.
    d0 = n_drop;
    for (int i = 0; i < 20; i++) begin
      d = 10'($urandom);
      exp_q.push_back(model(d));
      send(d);
      if (i < 19) repeat (70) @(negedge sysclk);
    end
    wait_idle("b2b", 300);
    for (int i = 0; i < 20; i++) check_frame("b2b");
    check_busy("b2b", 20 * 72);
    chk("b2b_dropped", n_drop - d0, 0);

    // Overrun: A sent, B overwritten by C, C follows A directly.
    d0 = n_drop;
    exp_q.push_back(16'h3448);
    send(10'h112);
    repeat (8) @(negedge sysclk);
    send(10'h2CC);
    repeat (8) @(negedge sysclk);
    exp_q.push_back(16'h3ECC);
    send(10'h3B3);
    wait_idle("ovr", 400);
    check_frame("ovr_a");
    check_frame("ovr_c");
    check_busy("ovr", 144);
    chk("ovr_dropped", n_drop - d0, 1);

    // Reset mid-SHIFT after 7 bits.
    send(10'h0F0);
    n = 0;
    while (rises != 7 && n < 200) begin
      @(posedge sysclk);
      n++;
    end
    chk("mid_rst_reach_bit7", rises, 7);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst_async");
    repeat (3) @(posedge sysclk);
    #1;
    got_q.delete(); rise_q.delete(); cs_q.delete(); ldac_q.delete(); busy_q.delete();
    @(negedge sysclk);
    rst_n = 1'b1;
    repeat (2) @(negedge sysclk);
    exp_q.push_back(16'h3554);
    send(10'h155);
    wait_idle("post_rst", 200);
    check_frame("post_rst");
    check_busy("post_rst", 72);
    chk("leftover_frames", got_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serialises the 10-bit output samples of the voice-processing datapath into 16-bit SPI write frames for an MCP4911-class 10-bit DAC. It sits directly downstream of the processing stage: it consumes that stage's registered 10-bit DAC code, already offset-binary, together with a one-cycle load strobe. It drives chip-select, serial clock, serial data and a latch strobe. A one-deep pending buffer absorbs a sample that arrives while a frame is still in flight.

## Interface
- `CLK_DIV`, default 2: sysclk cycles per SCK half-period and per setup/hold/gap phase; legal range 1–255.
- `BUF_BIT`, default 0: DAC VREF buffer bit.
- `GA_N_BIT`, default 1: DAC gain bit, 1 = 1x.
- `sysclk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset. The design has one clock; reset is asynchronous and active-low.
- `data_in` input 10: DAC code, sampled when `load`=1.
- `load` input 1: one-cycle strobe, new sample available.
- `busy` output 1: high while a frame or a pending sample is outstanding.
- `dropped` output 1: one-cycle pulse when a pending sample is overwritten.
- `dac_cs_n` output 1: SPI chip select, active low.
- `dac_sck` output 1: SPI clock, idle low; DAC samples on the rising edge.
- `dac_sdi` output 1: SPI data, MSB first.
- `dac_ldac_n` output 1: DAC latch strobe, active low.

## Operation
- Frame word is `{1'b0, BUF_BIT, GA_N_BIT, 1'b1 (SHDN_n), data_in[9:0], 2'b00}`, 16 bits, shifted MSB first.
- FSM states and dwell times (each dwell counted by the phase tick, i.e. CLK_DIV cycles):
  - IDLE: leaves for CS_SETUP when `load`=1 or pending is valid.
  - CS_SETUP: one dwell, then goes to SHIFT.
  - SHIFT: 16 bits × 2 dwells (SCK low phase, then SCK high phase), then goes to CS_HOLD.
  - CS_HOLD: one dwell, then goes to CS_GAP.
  - CS_GAP: one dwell, then goes to LDAC.
  - LDAC: one dwell, then goes to IDLE, or directly to CS_SETUP if work is waiting.
- Output levels per state:
  - `dac_cs_n`=0 in CS_SETUP, SHIFT and CS_HOLD; 1 otherwise.
  - `dac_sck`=1 only in SHIFT high phases.
  - `dac_ldac_n`=0 only in LDAC.
  - `dac_sdi` = shift register MSB while `dac_cs_n`=0; 0 otherwise.
- Shift register loads the frame word on entry to CS_SETUP and shifts left by 1 at the end of each SCK high phase.
- Pending buffer (1 entry):
  - `load` outside IDLE, or at the LDAC exit cycle, writes pending.
  - A write that hits a valid pending entry overwrites it and pulses `dropped`.
  - Pending is consumed on entry to CS_SETUP.
  - If `load` coincides with the LDAC exit while pending is valid, the new `data_in` is sent, the old pending entry is discarded, and `dropped` pulses.
- `busy` = (state≠IDLE) | pending_valid.

## Timing
- All outputs are registered.
- Reset values: `dac_cs_n`=1, `dac_sck`=0, `dac_sdi`=0, `dac_ldac_n`=1, `busy`=0, `dropped`=0, state=IDLE, pending cleared, phase counter 0.
- `load` sampled at edge N while IDLE: `dac_cs_n` falls and `busy` rises after edge N.
- First SCK rise comes 2·CLK_DIV cycles after edge N.
- Full frame, from the `dac_cs_n` fall to the return to IDLE, takes 36·CLK_DIV cycles (72 at the default).
- SDI changes only at SCK falling edges or at CS fall, so setup and hold are each CLK_DIV cycles.
- Reset asserted mid-frame forces the reset values immediately, with no waiting for clock. Any partial frame is abandoned; the DAC ignores it because CS rises before LDAC.
- The phase counter restarts at 0 on every state change.

## Structure
- Shared package `dac_pkg` holds:
  - state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP, LDAC);
  - `FRAME_W`=16 and `DATA_W`=10;
  - config bit positions.
- One sub-module, `phase_tick`: a divide-by-CLK_DIV counter that emits a one-cycle tick and clears on a state change. Everything else stays in `dac_spi_tx`.

## Test plan
- Reset: hold `rst_n`=0 for 5 cycles, then release. Outputs stay at reset values, with `busy`=0, until the first `load`.
- Single sample, `data_in`=10'h2A5, CLK_DIV=2: bits captured on `dac_sck` rises = 16'h3A94. `dac_cs_n` stays low 68 cycles, `dac_ldac_n` low 2 cycles, `busy` high 72 cycles.
- Extremes: 10'h000 → 16'h3000; 10'h3FF → 16'h3FFC. Exactly 16 SCK rises per frame.
- Back-to-back: `load` every 72 cycles for 20 samples. Every frame is correct, `dropped` never pulses, and there are no idle cycles beyond the gap.
- Overrun: `load` with values A, B, C at cycles 0, 10 and 20. A is sent, `dropped` pulses once (B overwritten), and C is sent as the next frame.
- Reset mid-SHIFT after 7 bits: `dac_cs_n`=1 and `dac_sck`=0 asynchronously. The next `load` of 10'h155 sends 16'h3554 correctly.
